// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding and default operand width.
package serial_subtractor_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus
// between a controller and the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// Half subtractor cell: difference and borrow of x - y.
// Two of these chain into a full subtractor.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock,
// LSB first, with a single borrow flip-flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             bff;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic d1, bo1, d, bo2, bout, last;

  half_subtractor hs1 (
    .x  (sa[0]),
    .y  (sb[0]),
    .d  (d1),
    .bo (bo1)
  );

  half_subtractor hs2 (
    .x  (d1),
    .y  (bff),
    .d  (d),
    .bo (bo2)
  );

  assign bout = bo1 | bo2;
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = SHIFT;
      SHIFT:   if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // res collects the low WIDTH-1 result bits; the final bit
  // joins them directly on the last SHIFT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      cnt      <= '0;
      bff      <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            cnt <= '0;
            bff <= 1'b0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= (WIDTH-1)'({d, res} >> 1);
          bff <= bout;
          cnt <= cnt + 1'b1;
          if (last) begin
            diff_q   <= {d, res};
            borrow_q <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and small-width exhaustive checks
// for the bit-serial subtractor.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  serial_subtractor_if #(.WIDTH(8)) s8 ();
  serial_subtractor_if #(.WIDTH(2)) s2 ();
  serial_subtractor_if #(.WIDTH(4)) s4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .bus (s8)
  );
  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk (clk), .rst (rst), .bus (s2)
  );
  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .bus (s4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op8(input string tag,
                     input logic [7:0] av,
                     input logic [7:0] bv,
                     input logic [7:0] ed,
                     input logic eb);
    int lat;
    int nb;
    @(negedge clk);
    s8.start = 1'b1;
    s8.a = av;
    s8.b = bv;
    @(negedge clk);
    s8.start = 1'b0;
    lat = 0;
    nb = 0;
    while (!s8.done && lat < 40) begin
      if (s8.busy) nb++;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".done"}, 32'(s8.done), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'd8);
    chk({tag, ".busy"}, 32'(nb), 32'd8);
    chk({tag, ".diff"}, 32'(s8.diff), 32'(ed));
    chk({tag, ".borrow"}, 32'(s8.borrow), 32'(eb));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(s8.done), 32'd0);
  endtask

  initial begin
    int n;
    int nd;
    logic [7:0] dsave;
    logic bsave;
    logic bz [0:18];
    logic dn [0:18];
    logic [7:0] dh;
    logic [1:0] a2, b2, e2;
    logic [3:0] a4, b4, e4;

    s8.start = 1'b0; s8.a = '0; s8.b = '0;
    s2.start = 1'b0; s2.a = '0; s2.b = '0;
    s4.start = 1'b0; s4.a = '0; s4.b = '0;

    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(s8.busy), 32'd0);
    chk("rst.done", 32'(s8.done), 32'd0);
    chk("rst.diff", 32'(s8.diff), 32'd0);
    chk("rst.borrow", 32'(s8.borrow), 32'd0);
    rst = 1'b0;

    op8("basic", 8'd5, 8'd3, 8'd2, 1'b0);
    op8("under1", 8'd3, 8'd5, 8'hFE, 1'b1);
    op8("under2", 8'h00, 8'h01, 8'hFF, 1'b1);
    op8("max", 8'hFF, 8'h00, 8'hFF, 1'b0);
    op8("eq", 8'hA5, 8'hA5, 8'h00, 1'b0);
    op8("zero", 8'h00, 8'h00, 8'h00, 1'b0);

    // second start during SHIFT must be dropped
    @(negedge clk);
    s8.start = 1'b1; s8.a = 8'd10; s8.b = 8'd4;
    @(negedge clk);
    s8.start = 1'b0;
    repeat (3) @(negedge clk);
    s8.start = 1'b1; s8.a = 8'd1; s8.b = 8'd2;
    @(negedge clk);
    s8.start = 1'b0; s8.a = '0; s8.b = '0;
    nd = 0;
    dsave = '0;
    bsave = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s8.done) begin
        nd++;
        dsave = s8.diff;
        bsave = s8.borrow;
      end
      @(negedge clk);
    end
    chk("ign.ndone", 32'(nd), 32'd1);
    chk("ign.diff", 32'(dsave), 32'd6);
    chk("ign.borrow", 32'(bsave), 32'd0);

    // start held high: re-accepted on first IDLE edge
    @(negedge clk);
    s8.start = 1'b1; s8.a = 8'd5; s8.b = 8'd3;
    dh = '0;
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      bz[i] = s8.busy;
      dn[i] = s8.done;
      if (i == 18) dh = s8.diff;
    end
    s8.start = 1'b0;
    chk("hold.done1", 32'(dn[8]), 32'd1);
    chk("hold.idle", 32'(bz[9]), 32'd0);
    chk("hold.rebusy", 32'(bz[10]), 32'd1);
    chk("hold.done2", 32'(dn[18]), 32'd1);
    chk("hold.diff", 32'(dh), 32'd2);
    @(negedge clk);

    // reset four cycles into SHIFT
    s8.start = 1'b1; s8.a = 8'd200; s8.b = 8'd1;
    @(negedge clk);
    s8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.busy_pre", 32'(s8.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.busy", 32'(s8.busy), 32'd0);
    chk("mid.done", 32'(s8.done), 32'd0);
    chk("mid.diff", 32'(s8.diff), 32'd0);
    chk("mid.borrow", 32'(s8.borrow), 32'd0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (s8.done) nd++;
    end
    chk("mid.nodone", 32'(nd), 32'd0);
    op8("after", 8'd9, 8'd9, 8'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      a2 = 2'(i >> 2);
      b2 = 2'(i);
      e2 = a2 - b2;
      @(negedge clk);
      s2.start = 1'b1; s2.a = a2; s2.b = b2;
      @(negedge clk);
      s2.start = 1'b0;
      n = 0;
      while (!s2.done && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("w2.%0d", i),
          {29'd0, s2.done, s2.borrow, s2.diff[1]} << 1 | 32'(s2.diff[0]),
          {29'd0, 1'b1, (a2 < b2), e2[1]} << 1 | 32'(e2[0]));
    end

    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4);
      b4 = 4'(i);
      e4 = a4 - b4;
      @(negedge clk);
      s4.start = 1'b1; s4.a = a4; s4.b = b4;
      @(negedge clk);
      s4.start = 1'b0;
      n = 0;
      while (!s4.done && n < 12) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("w4.%0d", i),
          {26'd0, s4.done, s4.borrow, s4.diff},
          {26'd0, 1'b1, (a4 < b4), e4});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
